// File: rtl/ysyx_25040111_axi_sram_pkg.sv
// Shared definitions for the single-beat AXI SRAM slave.
//   - read/write FSM state encodings
//   - AXI response codes
//   - resp_decode(): response code for an address/len/last combination
package ysyx_25040111_axi_sram_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_WAIT = 2'd2,
    W_RESP = 2'd3
  } w_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int LAT_W = 4;

  // Decode error wins over slave error. The unsigned offset wraps to a huge
  // value for addresses below base, so one compare covers both range ends.
  function automatic logic [1:0] resp_decode(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] span,
                                             input logic [7:0]  len,
                                             input logic        last);
    logic [31:0] off;
    off = addr - base;
    if (off >= span)                  return RESP_DECERR;
    else if ((len != 8'd0) || !last)  return RESP_SLVERR;
    else                              return RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_25040111_axi_sram_if.sv
// AXI4 subset bus between a master and the SRAM slave (single-beat only).
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both 1; once valid is raised the sender holds valid and
// its payload stable until that edge, and ready never waits on anything but
// the receiver's own state.
// Modports: master drives AW/W/AR payloads and bready/rready; slave drives
// awready/wready/arready and the B and R payloads.
interface ysyx_25040111_axi_sram_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp,
           rid, rlast
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp,
           rid, rlast
  );
endinterface

// File: rtl/ysyx_25040111_axi_sram_lat_cnt.sv
// Latency down-counter used by both SRAM channels.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_load       : load i_load_val this edge
//   i_load_val   : start value
//   o_done       : count has reached zero
module ysyx_25040111_lat_cnt
  import ysyx_25040111_axi_sram_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ysyx_25040111_axi_sram.sv
// Single-beat AXI SRAM slave with independent read and write channels.
//   clk, rst_n      : clock, synchronous active-low reset
//   io_slave        : AXI subset bus (slave modport)
//   o_dbg_r_state   : read FSM state
//   o_dbg_w_state   : write FSM state
// Parameters: BASE_ADDR (byte address of word 0), DEPTH_WORDS (power of two),
// LATENCY (wait cycles between acceptance and response, 0..15).
module ysyx_25040111_axi_sram
  import ysyx_25040111_axi_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ysyx_25040111_axi_sram_if.slave  io_slave,
  output r_state_e                 o_dbg_r_state,
  output w_state_e                 o_dbg_w_state
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam bit          LAT_ZERO = (LATENCY == 0);
  // WAIT lasts LATENCY cycles: load LATENCY-1 and leave when the count is 0.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_ZERO ? '0 : LAT_W'(LATENCY - 1);

  logic [31:0] r_mem [DEPTH_WORDS];

  // ---------------- read channel ----------------
  r_state_e    r_rstate;
  logic [31:0] r_araddr;
  logic [3:0]  r_arid;
  logic [7:0]  r_arlen;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rid;

  logic             w_ar_hs;
  logic             w_rlat_done;
  logic [31:0]      w_rd_addr;
  logic [7:0]       w_rd_len;
  logic [3:0]       w_rd_id;
  logic [1:0]       w_rd_resp;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_ar_hs = io_slave.arvalid & r_arready;
  // With zero latency the response is built straight from the AR payload.
  assign w_rd_addr = LAT_ZERO ? io_slave.araddr : r_araddr;
  assign w_rd_len  = LAT_ZERO ? io_slave.arlen  : r_arlen;
  assign w_rd_id   = LAT_ZERO ? io_slave.arid   : r_arid;
  assign w_rd_resp = resp_decode(w_rd_addr, BASE_ADDR, SPAN, w_rd_len, 1'b1);
  assign w_rd_idx  = IDX_W'((w_rd_addr - BASE_ADDR) >> 2);

  ysyx_25040111_lat_cnt u_rlat (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ar_hs),
    .i_load_val (LAT_LOAD),
    .o_done     (w_rlat_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_araddr  <= '0;
      r_arid    <= '0;
      r_arlen   <= '0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_hs) begin
          r_araddr  <= io_slave.araddr;
          r_arid    <= io_slave.arid;
          r_arlen   <= io_slave.arlen;
          r_arready <= 1'b0;
          if (LAT_ZERO) begin
            r_rstate <= R_RESP;
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rid    <= w_rd_id;
            r_rdata  <= (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
          end else begin
            r_rstate <= R_WAIT;
          end
        end
        // Storage is sampled on this edge; a same-edge write is not seen.
        R_WAIT: if (w_rlat_done) begin
          r_rstate <= R_RESP;
          r_rvalid <= 1'b1;
          r_rresp  <= w_rd_resp;
          r_rid    <= w_rd_id;
          r_rdata  <= (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
        end
        R_RESP: if (io_slave.rready) begin
          r_rstate  <= R_IDLE;
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
        end
      endcase
    end
  end

  assign io_slave.arready = r_arready;
  assign io_slave.rvalid  = r_rvalid;
  assign io_slave.rlast   = r_rvalid;
  assign io_slave.rdata   = r_rdata;
  assign io_slave.rresp   = r_rresp;
  assign io_slave.rid     = r_rid;
  assign o_dbg_r_state    = r_rstate;

  // ---------------- write channel ----------------
  w_state_e    r_wstate;
  logic [31:0] r_awaddr;
  logic [3:0]  r_awid;
  logic [7:0]  r_awlen;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_wlat_done;
  logic [1:0]       w_wr_resp;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_we;

  assign w_aw_hs   = io_slave.awvalid & r_awready;
  assign w_w_hs    = io_slave.wvalid & r_wready;
  assign w_wr_resp = resp_decode(r_awaddr, BASE_ADDR, SPAN, r_awlen, io_slave.wlast);
  assign w_wr_idx  = IDX_W'((r_awaddr - BASE_ADDR) >> 2);
  // Gated by rst_n so a beat presented during reset never lands in storage.
  assign w_we      = w_w_hs & (w_wr_resp == RESP_OKAY) & rst_n;

  ysyx_25040111_lat_cnt u_wlat (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_w_hs),
    .i_load_val (LAT_LOAD),
    .o_done     (w_wlat_done)
  );

  // Storage has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (io_slave.wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= io_slave.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_awlen   <= '0;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (w_aw_hs) begin
          r_awaddr  <= io_slave.awaddr;
          r_awid    <= io_slave.awid;
          r_awlen   <= io_slave.awlen;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (w_w_hs) begin
          r_wready <= 1'b0;
          r_bresp  <= w_wr_resp;
          r_bid    <= r_awid;
          if (LAT_ZERO) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
          end else begin
            r_wstate <= W_WAIT;
          end
        end
        W_WAIT: if (w_wlat_done) begin
          r_wstate <= W_RESP;
          r_bvalid <= 1'b1;
        end
        W_RESP: if (io_slave.bready) begin
          r_wstate  <= W_IDLE;
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_bvalid  <= 1'b0;
          r_wready  <= 1'b0;
          r_awready <= 1'b1;
        end
      endcase
    end
  end

  assign io_slave.awready = r_awready;
  assign io_slave.wready  = r_wready;
  assign io_slave.bvalid  = r_bvalid;
  assign io_slave.bresp   = r_bresp;
  assign io_slave.bid     = r_bid;
  assign o_dbg_w_state    = r_wstate;

endmodule
